// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone master between the SCR1 IMEM and DMEM ports.
// Each grant runs a single cycle, then a one-cycle response slot. A watchdog ends cycles that are never acknowledged.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            imem_req_i,
  input  logic [AW-1:0]   imem_addr_i,
  output logic [DW-1:0]   imem_rdata_o,
  output logic            imem_ready_o,
  output logic            imem_err_o,
  input  logic            dmem_req_i,
  input  logic [AW-1:0]   dmem_addr_i,
  input  logic [DW-1:0]   dmem_wdata_i,
  input  logic [DW/8-1:0] dmem_wstrb_i,
  output logic [DW-1:0]   dmem_rdata_o,
  output logic            dmem_ready_o,
  output logic            dmem_err_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  output logic [DW/8-1:0] wbm_sel_o,
  input  logic [DW-1:0]   wbm_dat_i,
  input  logic            wbm_ack_i,
  input  logic            wbm_err_i
);

  localparam int SW  = DW / 8;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          state, state_next;
  logic            last_dmem, last_dmem_next;
  logic            cur_dmem, cur_dmem_next;
  logic            grant_dmem;
  logic [WDW-1:0]  wd, wd_next, wd_inc;
  logic            cyc, cyc_next;
  logic            we, we_next;
  logic [AW-1:0]   adr, adr_next;
  logic [DW-1:0]   dat, dat_next;
  logic [SW-1:0]   sel, sel_next;
  logic [DW-1:0]   imem_rdata, imem_rdata_next, dmem_rdata, dmem_rdata_next;
  logic            imem_ready, imem_ready_next, imem_err, imem_err_next;
  logic            dmem_ready, dmem_ready_next, dmem_err, dmem_err_next;

  assign wd_inc = wd + WDW'(1);

  always_comb begin
    state_next      = state;
    last_dmem_next  = last_dmem;
    cur_dmem_next   = cur_dmem;
    grant_dmem      = 1'b0;
    wd_next         = wd;
    cyc_next        = cyc;
    we_next         = we;
    adr_next        = adr;
    dat_next        = dat;
    sel_next        = sel;
    imem_rdata_next = imem_rdata;
    dmem_rdata_next = dmem_rdata;
    imem_ready_next = 1'b0;
    imem_err_next   = 1'b0;
    dmem_ready_next = 1'b0;
    dmem_err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (imem_req_i || dmem_req_i) begin
          // Under contention the side that did not win last time gets the bus.
          grant_dmem     = dmem_req_i && (!imem_req_i || !last_dmem);
          cur_dmem_next  = grant_dmem;
          last_dmem_next = grant_dmem;
          cyc_next       = 1'b1;
          wd_next        = '0;
          state_next     = BUS;
          if (grant_dmem) begin
            adr_next = dmem_addr_i;
            dat_next = dmem_wdata_i;
            we_next  = |dmem_wstrb_i;
            sel_next = we_next ? dmem_wstrb_i : '1;
          end else begin
            adr_next = imem_addr_i;
            dat_next = '0;
            we_next  = 1'b0;
            sel_next = '1;
          end
        end
      end
      BUS: begin
        wd_next = wd_inc;
        if (wbm_ack_i || wbm_err_i) begin
          cyc_next   = 1'b0;
          we_next    = 1'b0;
          state_next = RESP;
          if (cur_dmem) begin
            dmem_ready_next = 1'b1;
            dmem_err_next   = wbm_err_i;
            dmem_rdata_next = wbm_dat_i;
          end else begin
            imem_ready_next = 1'b1;
            imem_err_next   = wbm_err_i;
            imem_rdata_next = wbm_dat_i;
          end
        end else if (wd_inc == WDW'(TIMEOUT)) begin
          cyc_next   = 1'b0;
          we_next    = 1'b0;
          state_next = RESP;
          if (cur_dmem) begin
            dmem_ready_next = 1'b1;
            dmem_err_next   = 1'b1;
            dmem_rdata_next = '0;
          end else begin
            imem_ready_next = 1'b1;
            imem_err_next   = 1'b1;
            imem_rdata_next = '0;
          end
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_dmem  <= 1'b1;
      cur_dmem   <= 1'b0;
      wd         <= '0;
      cyc        <= 1'b0;
      we         <= 1'b0;
      adr        <= '0;
      dat        <= '0;
      sel        <= '0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
      imem_ready <= 1'b0;
      imem_err   <= 1'b0;
      dmem_ready <= 1'b0;
      dmem_err   <= 1'b0;
    end else begin
      state      <= state_next;
      last_dmem  <= last_dmem_next;
      cur_dmem   <= cur_dmem_next;
      wd         <= wd_next;
      cyc        <= cyc_next;
      we         <= we_next;
      adr        <= adr_next;
      dat        <= dat_next;
      sel        <= sel_next;
      imem_rdata <= imem_rdata_next;
      dmem_rdata <= dmem_rdata_next;
      imem_ready <= imem_ready_next;
      imem_err   <= imem_err_next;
      dmem_ready <= dmem_ready_next;
      dmem_err   <= dmem_err_next;
    end
  end

  assign wbm_cyc_o    = cyc;
  assign wbm_stb_o    = cyc;
  assign wbm_we_o     = we;
  assign wbm_adr_o    = adr;
  assign wbm_dat_o    = dat;
  assign wbm_sel_o    = sel;
  assign imem_rdata_o = imem_rdata;
  assign imem_ready_o = imem_ready;
  assign imem_err_o   = imem_err;
  assign dmem_rdata_o = dmem_rdata;
  assign dmem_ready_o = dmem_ready;
  assign dmem_err_o   = dmem_err;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: a per-cycle vector table plus hand-written timeout and async-reset sequences.
`timescale 1ns/1ps
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic        imem_ready, imem_err;
  logic        dmem_req = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [3:0]  dmem_wstrb = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready, dmem_err;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic [31:0] dat_i = '0;
  logic        ack = 1'b0;
  logic        err = 1'b0;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .imem_req_i(imem_req), .imem_addr_i(imem_addr), .imem_rdata_o(imem_rdata),
    .imem_ready_o(imem_ready), .imem_err_o(imem_err),
    .dmem_req_i(dmem_req), .dmem_addr_i(dmem_addr), .dmem_wdata_i(dmem_wdata),
    .dmem_wstrb_i(dmem_wstrb), .dmem_rdata_o(dmem_rdata),
    .dmem_ready_o(dmem_ready), .dmem_err_o(dmem_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err)
  );

  // One row = inputs held for a cycle, and the registered outputs expected after the next edge.
  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic [31:0] daddr; logic [31:0] dwdata; logic [3:0] dstrb;
    logic ack; logic err; logic [31:0] rdat;
    logic cyc; logic we; logic [31:0] adr; logic [31:0] dato; logic [3:0] sel;
    logic irdy; logic ierr; logic [31:0] irdata;
    logic drdy; logic derr; logic [31:0] drdata;
  } vec_t;

  function automatic vec_t mk(
    input logic ireq, input logic [31:0] iaddr,
    input logic dreq, input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dstrb,
    input logic a, input logic e, input logic [31:0] rdat,
    input logic c, input logic w, input logic [31:0] ad, input logic [31:0] dto, input logic [3:0] sl,
    input logic irdy, input logic ierr, input logic [31:0] irdata,
    input logic drdy, input logic derr, input logic [31:0] drdata);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.daddr = daddr; v.dwdata = dwdata; v.dstrb = dstrb;
    v.ack = a; v.err = e; v.rdat = rdat;
    v.cyc = c; v.we = w; v.adr = ad; v.dato = dto; v.sel = sl;
    v.irdy = irdy; v.ierr = ierr; v.irdata = irdata;
    v.drdy = drdy; v.derr = derr; v.drdata = drdata;
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    imem_req = v.ireq; imem_addr = v.iaddr;
    dmem_req = v.dreq; dmem_addr = v.daddr; dmem_wdata = v.dwdata; dmem_wstrb = v.dstrb;
    ack = v.ack; err = v.err; dat_i = v.rdat;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkField({tag, ".cyc"}, {31'd0, cyc}, {31'd0, v.cyc});
    checkField({tag, ".stb"}, {31'd0, stb}, {31'd0, v.cyc});
    checkField({tag, ".we"}, {31'd0, we}, {31'd0, v.we});
    checkField({tag, ".adr"}, adr, v.adr);
    checkField({tag, ".dat_o"}, dat_o, v.dato);
    checkField({tag, ".sel"}, {28'd0, sel}, {28'd0, v.sel});
    checkField({tag, ".imem_ready"}, {31'd0, imem_ready}, {31'd0, v.irdy});
    checkField({tag, ".imem_err"}, {31'd0, imem_err}, {31'd0, v.ierr});
    checkField({tag, ".imem_rdata"}, imem_rdata, v.irdata);
    checkField({tag, ".dmem_ready"}, {31'd0, dmem_ready}, {31'd0, v.drdy});
    checkField({tag, ".dmem_err"}, {31'd0, dmem_err}, {31'd0, v.derr});
    checkField({tag, ".dmem_rdata"}, dmem_rdata, v.drdata);
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global time limit exceeded");
  end

  initial begin
    vec_t vecs[$];
    vec_t zero;
    vec_t t;

    zero = mk(0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0);

    // single IMEM read with a one-cycle wait state
    vecs.push_back(mk(1,'h100, 0,0,0,0, 0,0,0,            1,0,'h100,0,'hF, 0,0,0,          0,0,0));
    vecs.push_back(mk(1,'h100, 0,0,0,0, 0,0,0,            1,0,'h100,0,'hF, 0,0,0,          0,0,0));
    vecs.push_back(mk(1,'h100, 0,0,0,0, 1,0,'hDEADBEEF,   0,0,'h100,0,'hF, 1,0,'hDEADBEEF, 0,0,0));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,            0,0,'h100,0,'hF, 0,0,'hDEADBEEF, 0,0,0));
    // DMEM byte write
    vecs.push_back(mk(0,0, 1,'h2000,'hAA,'h1, 0,0,0,          1,1,'h2000,'hAA,'h1, 0,0,'hDEADBEEF, 0,0,0));
    vecs.push_back(mk(0,0, 1,'h2000,'hAA,'h1, 1,0,'h12345678, 0,0,'h2000,'hAA,'h1, 0,0,'hDEADBEEF, 1,0,'h12345678));
    vecs.push_back(mk(0,0, 0,0,0,0,           0,0,0,          0,0,'h2000,'hAA,'h1, 0,0,'hDEADBEEF, 0,0,'h12345678));
    // continuous contention: I, D, I, D with one dead cycle after each ready
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          1,0,'h300,0,'hF,          0,0,'hDEADBEEF, 0,0,'h12345678));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 1,0,'hA0A0A0A0, 0,0,'h300,0,'hF,          1,0,'hA0A0A0A0, 0,0,'h12345678));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          0,0,'h300,0,'hF,          0,0,'hA0A0A0A0, 0,0,'h12345678));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          1,0,'h400,'h11223344,'hF, 0,0,'hA0A0A0A0, 0,0,'h12345678));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 1,0,'hB1B1B1B1, 0,0,'h400,'h11223344,'hF, 0,0,'hA0A0A0A0, 1,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          0,0,'h400,'h11223344,'hF, 0,0,'hA0A0A0A0, 0,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          1,0,'h300,0,'hF,          0,0,'hA0A0A0A0, 0,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 1,0,'hC2C2C2C2, 0,0,'h300,0,'hF,          1,0,'hC2C2C2C2, 0,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          0,0,'h300,0,'hF,          0,0,'hC2C2C2C2, 0,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 0,0,0,          1,0,'h400,'h11223344,'hF, 0,0,'hC2C2C2C2, 0,0,'hB1B1B1B1));
    vecs.push_back(mk(1,'h300, 1,'h400,'h11223344,0, 1,0,'hD3D3D3D3, 0,0,'h400,'h11223344,'hF, 0,0,'hC2C2C2C2, 1,0,'hD3D3D3D3));
    vecs.push_back(mk(0,0,     0,0,0,0,                0,0,0,          0,0,'h400,'h11223344,'hF, 0,0,'hC2C2C2C2, 0,0,'hD3D3D3D3));
    // bus error, a new address presented during the dead cycle, then ack+err together
    vecs.push_back(mk(1,'h500, 0,0,0,0, 0,0,0,          1,0,'h500,0,'hF, 0,0,'hC2C2C2C2, 0,0,'hD3D3D3D3));
    vecs.push_back(mk(1,'h500, 0,0,0,0, 0,1,'hEEEE0000, 0,0,'h500,0,'hF, 1,1,'hEEEE0000, 0,0,'hD3D3D3D3));
    vecs.push_back(mk(1,'h504, 0,0,0,0, 0,0,0,          0,0,'h500,0,'hF, 0,0,'hEEEE0000, 0,0,'hD3D3D3D3));
    vecs.push_back(mk(1,'h504, 0,0,0,0, 0,0,0,          1,0,'h504,0,'hF, 0,0,'hEEEE0000, 0,0,'hD3D3D3D3));
    vecs.push_back(mk(1,'h504, 0,0,0,0, 1,1,'h55AA55AA, 0,0,'h504,0,'hF, 1,1,'h55AA55AA, 0,0,'hD3D3D3D3));
    vecs.push_back(mk(0,0,     0,0,0,0, 0,0,0,          0,0,'h504,0,'hF, 0,0,'h55AA55AA, 0,0,'hD3D3D3D3));

    repeat (2) @(posedge clk);
    #1;
    checkOutput(zero, "reset_hold");
    rst = 1'b0;
    checkOutput(zero, "reset_release");

    for (int i = 0; i < vecs.size(); i++)
      runVec(vecs[i], $sformatf("vec%0d", i));

    // watchdog: never-acked DMEM read holds cyc for exactly 8 cycles, slave data must not leak through
    t = mk(0,0, 1,'h9000,0,0, 0,0,'hFFFFFFFF, 1,0,'h9000,0,'hF, 0,0,'h55AA55AA, 0,0,'hD3D3D3D3);
    for (int k = 0; k < 8; k++)
      runVec(t, $sformatf("wd_bus%0d", k));
    runVec(mk(0,0, 1,'h9000,0,0, 0,0,'hFFFFFFFF, 0,0,'h9000,0,'hF, 0,0,'h55AA55AA, 1,1,0), "wd_expire");
    runVec(mk(0,0, 0,0,0,0, 0,0,0, 0,0,'h9000,0,'hF, 0,0,'h55AA55AA, 0,0,0), "wd_resp");
    runVec(mk(0,0, 1,'h9004,'hCAFEF00D,'hF, 0,0,0,          1,1,'h9004,'hCAFEF00D,'hF, 0,0,'h55AA55AA, 0,0,0), "wd_next_req");
    runVec(mk(0,0, 1,'h9004,'hCAFEF00D,'hF, 1,0,'h0BADF00D, 0,0,'h9004,'hCAFEF00D,'hF, 0,0,'h55AA55AA, 1,0,'h0BADF00D), "wd_next_ack");
    runVec(mk(0,0, 0,0,0,0, 0,0,0, 0,0,'h9004,'hCAFEF00D,'hF, 0,0,'h55AA55AA, 0,0,'h0BADF00D), "wd_next_idle");

    // async reset in the middle of a bus cycle, after IMEM won last
    runVec(mk(1,'h700, 0,0,0,0, 0,0,0, 1,0,'h700,0,'hF, 0,0,'h55AA55AA, 0,0,'h0BADF00D), "ar_bus");
    #2;
    rst = 1'b1;
    #1;
    checkField("ar_cyc_async", {31'd0, cyc}, 32'd0);
    checkField("ar_stb_async", {31'd0, stb}, 32'd0);
    applyStimulus(zero);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput(zero, "ar_after");
    runVec(mk(1,'h800, 1,'hA00,'h5,'h3, 0,0,0,    1,0,'h800,0,'hF, 0,0,0,     0,0,0), "ar_first_grant");
    runVec(mk(1,'h800, 1,'hA00,'h5,'h3, 1,0,'h77, 0,0,'h800,0,'hF, 1,0,'h77, 0,0,0), "ar_ready");
    #2;
    rst = 1'b1;
    #1;
    checkField("ar_ready_async", {31'd0, imem_ready}, 32'd0);
    applyStimulus(zero);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runVec(mk(1,'h804, 1,'hA04,'h6,'hC, 0,0,0, 1,0,'h804,0,'hF, 0,0,0, 0,0,0), "ar_regrant");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
